// File: rtl/ping_pong_ctrl_if.sv
// ping_pong_ctrl_if
// Groups the step strobe, the two button pulses, the counter feedback and the
// controller outputs into one bundle.
//   master : the environment side (drives tick/buttons/cnt_val)
//   slave  : the controller side (drives cnt_load/cnt_en/cnt_up/bounce/state)
interface ping_pong_ctrl_if;
  logic       tick;
  logic       btn_start;
  logic       btn_dir;
  logic [7:0] cnt_val;
  logic       cnt_load;
  logic       cnt_en;
  logic       cnt_up;
  logic [7:0] bounce;
  logic [1:0] state;

  modport master (
    output tick, btn_start, btn_dir, cnt_val,
    input  cnt_load, cnt_en, cnt_up, bounce, state
  );

  modport slave (
    input  tick, btn_start, btn_dir, cnt_val,
    output cnt_load, cnt_en, cnt_up, bounce, state
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// ping_pong_ctrl
// Controls an external BCD counter so that it bounces between MIN_BCD and
// MAX_BCD. Each tick in RUN becomes a one-cycle step command; at a limit the
// direction flips and the BCD bounce count advances. Manual direction
// reversal and start/pause/resume come from debounced one-cycle pulses.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport -- tick, btn_start, btn_dir, cnt_val in;
//          cnt_load, cnt_en, cnt_up, bounce, state out (all registered)
module ping_pong_ctrl #(
  parameter logic [7:0] MIN_BCD = 8'h00,
  parameter logic [7:0] MAX_BCD = 8'h15
) (
  input  logic           clk,
  input  logic           rst,
  ping_pong_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic       cnt_load_reg, cnt_load_next;
  logic       cnt_en_reg, cnt_en_next;
  logic       cnt_up_reg, cnt_up_next;
  logic [7:0] bounce_reg, bounce_next;
  logic       dir_eff;
  logic       stale;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_load_reg <= 1'b0;
      cnt_en_reg   <= 1'b0;
      cnt_up_reg   <= 1'b1;
      bounce_reg   <= 8'h00;
    end else begin
      state_reg    <= state_next;
      cnt_load_reg <= cnt_load_next;
      cnt_en_reg   <= cnt_en_next;
      cnt_up_reg   <= cnt_up_next;
      bounce_reg   <= bounce_next;
    end
  end

  // Direction after a manual toggle in this cycle; the limit check uses it.
  assign dir_eff = cnt_up_reg ^ bus.btn_dir;
  // cnt_val does not yet reflect a load/step that is being issued right now.
  assign stale   = cnt_load_reg | cnt_en_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_load_next = 1'b0;
    cnt_en_next   = 1'b0;
    cnt_up_next   = cnt_up_reg;
    bounce_next   = bounce_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.btn_start) begin
          state_next    = RUN;
          cnt_load_next = 1'b1;
          cnt_up_next   = 1'b1;
          bounce_next   = 8'h00;
        end
      end

      RUN: begin
        cnt_up_next = dir_eff;
        if (bus.btn_start) begin
          // Pausing takes priority over a coincident tick.
          state_next = PAUSE;
        end else if (bus.tick && !stale) begin
          cnt_en_next = 1'b1;
          if (dir_eff && (bus.cnt_val >= MAX_BCD)) begin
            cnt_up_next = 1'b0;
            bounce_next = bcd_inc(bounce_reg);
          end else if (!dir_eff && (bus.cnt_val <= MIN_BCD)) begin
            cnt_up_next = 1'b1;
            bounce_next = bcd_inc(bounce_reg);
          end
        end
      end

      PAUSE: begin
        cnt_up_next = dir_eff;
        if (bus.btn_start) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.state    = state_reg;
  assign bus.cnt_load = cnt_load_reg;
  assign bus.cnt_en   = cnt_en_reg;
  assign bus.cnt_up   = cnt_up_reg;
  assign bus.bounce   = bounce_reg;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// tb_ping_pong_ctrl
// Directed scenarios followed by a randomized run, checked every cycle against
// a behavioural model kept in decimal integers. A simple BCD counter model
// closes the cnt_val feedback loop.
module tb_ping_pong_ctrl;
  localparam logic [7:0] MIN_BCD = 8'h00;
  localparam logic [7:0] MAX_BCD = 8'h15;
  localparam int         MIN_DEC = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ping_pong_ctrl_if bus ();

  ping_pong_ctrl #(.MIN_BCD(MIN_BCD), .MAX_BCD(MAX_BCD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state 0 idle, 1 run, 2 pause; bounce as 0..99.
  int m_state  = 0;
  int m_up     = 1;
  int m_bounce = 0;
  int m_en     = 0;
  int m_load   = 0;
  int ctr      = 0;

  function automatic logic [7:0] to_bcd(input int d);
    return 8'(((d / 10) << 4) | (d % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic t, input logic s,
                            input logic d, input logic [7:0] v);
    int nst;
    int stale;
    if (r) begin
      m_state = 0; m_up = 1; m_bounce = 0; m_en = 0; m_load = 0;
      return;
    end
    // external counter reacts to the commands present before this edge
    if (m_load != 0)    ctr = MIN_DEC;
    else if (m_en != 0) ctr = (m_up != 0) ? (ctr + 1) % 100 : (ctr + 99) % 100;
    stale  = m_en | m_load;
    m_en   = 0;
    m_load = 0;
    nst    = m_state;
    if (m_state == 0) begin
      if (s) begin
        nst = 1; m_load = 1; m_up = 1; m_bounce = 0;
      end
    end else begin
      if (d) m_up = 1 - m_up;
      if (s) begin
        nst = (m_state == 1) ? 2 : 1;
      end else if (m_state == 1 && t && stale == 0) begin
        if (m_up == 1 && v >= MAX_BCD) begin
          m_up = 0; m_bounce = (m_bounce + 1) % 100;
        end else if (m_up == 0 && v <= MIN_BCD) begin
          m_up = 1; m_bounce = (m_bounce + 1) % 100;
        end
        m_en = 1;
      end
    end
    m_state = nst;
  endtask

  task automatic cycle(input logic r, input logic t, input logic s,
                       input logic d, input logic [7:0] v);
    rst           = r;
    bus.tick      = t;
    bus.btn_start = s;
    bus.btn_dir   = d;
    bus.cnt_val   = v;
    @(posedge clk);
    model_step(r, t, s, d, v);
    #1;
    chk("state",    8'(bus.state),    8'(m_state));
    chk("cnt_load", 8'(bus.cnt_load), 8'(m_load));
    chk("cnt_en",   8'(bus.cnt_en),   8'(m_en));
    chk("cnt_up",   8'(bus.cnt_up),   8'(m_up));
    chk("bounce",   bus.bounce,       to_bcd(m_bounce));
    $display("t=%0t rst=%0b tick=%0b start=%0b dir=%0b val=%02h | st=%0d ld=%0b en=%0b up=%0b b=%02h",
             $time, r, t, s, d, v, bus.state, bus.cnt_load, bus.cnt_en, bus.cnt_up, bus.bounce);
  endtask

  initial begin
    logic [7:0] v;
    // reset
    cycle(1, 1, 1, 1, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    chk("rst_state", 8'(bus.state), 8'h00);
    chk("rst_up",    8'(bus.cnt_up), 8'h01);

    // start: load for one cycle
    cycle(0, 0, 1, 1, 8'h00);
    chk("start_state", 8'(bus.state), 8'h01);
    chk("start_load",  8'(bus.cnt_load), 8'h01);
    chk("start_up",    8'(bus.cnt_up), 8'h01);
    cycle(0, 1, 0, 0, 8'h00);              // stale tick while loading
    chk("load_once", 8'(bus.cnt_load), 8'h00);
    chk("stale_tick", 8'(bus.cnt_en), 8'h00);

    // upper limit reversal
    cycle(0, 1, 0, 0, 8'h15);
    chk("max_en", 8'(bus.cnt_en), 8'h01);
    chk("max_up", 8'(bus.cnt_up), 8'h00);
    chk("max_bounce", bus.bounce, 8'h01);
    cycle(0, 0, 0, 0, 8'h14);

    // tick with btn_dir at lower limit: toggle wins, no bounce
    cycle(0, 1, 0, 1, 8'h00);
    chk("dirtick_en", 8'(bus.cnt_en), 8'h01);
    chk("dirtick_up", 8'(bus.cnt_up), 8'h01);
    chk("dirtick_bounce", bus.bounce, 8'h01);
    cycle(0, 0, 0, 0, 8'h01);

    // many reversals: passes 09->10 and 99->00
    for (int i = 0; i < 105; i++) begin
      v = (m_up != 0) ? 8'h15 : 8'h00;
      cycle(0, 1, 0, 0, v);
      if (m_bounce == 10) chk("bcd_carry", bus.bounce, 8'h10);
      if (m_bounce == 0)  chk("bcd_wrap",  bus.bounce, 8'h00);
      cycle(0, 0, 0, 0, v);
    end

    // pause ignores ticks
    cycle(0, 0, 1, 0, 8'h05);
    chk("pause_state", 8'(bus.state), 8'h02);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 8'h05);
      chk("pause_tick", 8'(bus.cnt_en), 8'h00);
    end
    cycle(0, 0, 1, 0, 8'h05);              // resume, no load
    chk("resume_load", 8'(bus.cnt_load), 8'h00);
    cycle(0, 0, 0, 0, 8'h05);
    cycle(0, 1, 1, 0, 8'h05);              // start+tick in RUN
    chk("starttick_state", 8'(bus.state), 8'h02);
    chk("starttick_en", 8'(bus.cnt_en), 8'h00);

    // reset right after a tick
    cycle(0, 0, 1, 0, 8'h05);
    cycle(0, 0, 0, 0, 8'h05);
    cycle(0, 1, 0, 0, 8'h05);
    chk("pre_rst_en", 8'(bus.cnt_en), 8'h01);
    cycle(1, 0, 0, 0, 8'h05);
    chk("rst_en", 8'(bus.cnt_en), 8'h00);
    chk("rst_state2", 8'(bus.state), 8'h00);
    chk("rst_up2", 8'(bus.cnt_up), 8'h01);
    ctr = 0;

    // randomized run with counter feedback
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(15) == 0) ? 8'($urandom) : to_bcd(ctr);
      cycle(($urandom_range(127) == 0), ($urandom_range(2) == 0),
            ($urandom_range(15) == 0), ($urandom_range(7) == 0), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ping_pong_ctrl.md
PING_PONG_CTRL -- requirements
Module: ping_pong_ctrl

Interface
REQ-001 SHALL have parameter MIN_BCD, default 8'h00, meaning lower bounce limit as two-digit BCD {tens,ones}.
REQ-002 SHALL have parameter MAX_BCD, default 8'h15, meaning upper bounce limit as two-digit BCD; MIN_BCD < MAX_BCD, both valid BCD.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tick  input  1  one-cycle step strobe from the clock divider.
REQ-006 SHALL have port btn_start  input  1  one-cycle debounced pulse: start/pause/resume.
REQ-007 SHALL have port btn_dir  input  1  one-cycle debounced pulse: manual direction reversal.
REQ-008 SHALL have port cnt_val  input  8  current counter value, BCD {tens,ones}, fed back from the counter datapath.
REQ-009 SHALL have port cnt_load  output  1  one-cycle command to load MIN_BCD into the counter.
REQ-010 SHALL have port cnt_en  output  1  one-cycle command to step the counter by 1.
REQ-011 SHALL have port cnt_up  output  1  step direction: 1 = increment, 0 = decrement; valid whenever cnt_en=1.
REQ-012 SHALL have port bounce  output  8  BCD count of automatic reversals, {tens,ones}.
REQ-013 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL implement FSM IDLE -> RUN on btn_start, with cnt_load=1 for exactly the following cycle, cnt_up set to 1, and bounce cleared to 8'h00.
REQ-016 SHALL move RUN -> PAUSE on btn_start and PAUSE -> RUN on btn_start, without asserting cnt_load.
REQ-017 SHALL never leave RUN or PAUSE except via rst; IDLE is entered only from reset.
REQ-018 SHALL, in RUN, on tick, assert cnt_en for exactly one cycle on the next cycle (latency 1), with cnt_up valid in that same cycle.
REQ-019 SHALL, at tick in RUN with cnt_up=1 and cnt_val >= MAX_BCD, flip cnt_up to 0, increment bounce, and issue the step as a decrement.
REQ-020 SHALL, at tick in RUN with cnt_up=0 and cnt_val <= MIN_BCD, flip cnt_up to 1, increment bounce, and issue the step as an increment.
REQ-021 SHALL compare cnt_val as an unsigned 8-bit value; non-BCD or out-of-range values follow the >=/<= rules of REQ-019/020.
REQ-022 SHALL ignore tick in IDLE and PAUSE: no cnt_en and no direction change.
REQ-023 SHALL ignore tick in the cycle cnt_load or cnt_en is asserted, because cnt_val is stale in that cycle.
REQ-024 SHALL toggle cnt_up on btn_dir in RUN or PAUSE without incrementing bounce; btn_dir is ignored in IDLE.
REQ-025 SHALL, when btn_dir and tick coincide in RUN, apply the toggle first, then apply the limit check of REQ-019/020 using the toggled direction.
REQ-026 SHALL, when btn_start and btn_dir coincide, apply the state transition and also the toggle, except in IDLE, where only the start takes effect.
REQ-027 SHALL, when btn_start and tick coincide in RUN, enter PAUSE and issue no step.
REQ-028 SHALL increment bounce in BCD, with ones 9 -> 0 carrying into tens, and 8'h99 -> 8'h00 wrapping.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=IDLE, cnt_load=0, cnt_en=0, cnt_up=1, and bounce=8'h00, regardless of other inputs.
REQ-030 SHALL, on rst asserted mid-RUN, drop any pending cnt_en or cnt_load in the next cycle.

Verification
REQ-031 SHALL cover: rst, then btn_start -> state=01, cnt_load=1 for one cycle, cnt_up=1, bounce=00.
REQ-032 SHALL cover: RUN, cnt_val=8'h15, cnt_up=1, tick -> next cycle cnt_en=1, cnt_up=0, bounce 00->01.
REQ-033 SHALL cover: RUN, cnt_val=8'h00, cnt_up=0, tick together with btn_dir -> toggle gives up, no bounce, cnt_en=1 with cnt_up=1.
REQ-034 SHALL cover: bounce=8'h99 and an automatic reversal -> bounce=8'h00; bounce=8'h09 -> 8'h10.
REQ-035 SHALL cover: PAUSE with ticks -> no cnt_en; btn_start and tick in the same cycle in RUN -> state=10 and no cnt_en.
REQ-036 SHALL cover: rst in the cycle after a tick in RUN -> cnt_en=0, state=00, cnt_up=1.
